// File: rtl/to_lower_stream_if.sv
// Byte stream valid/ready bundle shared by the converter input and output sides.
interface to_lower_stream_if;
  logic       valid;
  logic       ready;
  logic [7:0] data;

  modport master (output valid, output data, input  ready);
  modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/to_lower_stream.sv
// Streaming ASCII lowercase converter: converts at write into a small FIFO and
// keeps saturating accepted/converted byte counters.
module to_lower_stream #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  to_lower_stream_if.slave         in_if,
  to_lower_stream_if.master        out_if,
  input  logic                     clr_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [CNT_W-1:0]         byte_count_o,
  output logic [CNT_W-1:0]         conv_count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d, conv_cnt_q, conv_cnt_d;

  logic       push, pop, is_upper;
  logic [7:0] wr_byte;

  assign in_if.ready  = (level_q != LW'(DEPTH));
  assign out_if.valid = (level_q != '0);
  assign out_if.data  = out_if.valid ? mem_q[rd_ptr_q] : 8'h00;

  assign push     = in_if.valid && in_if.ready;
  assign pop      = out_if.valid && out_if.ready;
  assign is_upper = (in_if.data >= 8'd65) && (in_if.data <= 8'd90);
  assign wr_byte  = is_upper ? in_if.data + 8'd32 : in_if.data;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    byte_cnt_d = byte_cnt_q;
    conv_cnt_d = conv_cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    // clr takes priority over a same-cycle push
    if (clr_i) begin
      byte_cnt_d = '0;
      conv_cnt_d = '0;
    end else if (push) begin
      if (!(&byte_cnt_q))             byte_cnt_d = byte_cnt_q + CNT_W'(1);
      if (is_upper && !(&conv_cnt_q)) conv_cnt_d = conv_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      byte_cnt_q <= '0;
      conv_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      byte_cnt_q <= byte_cnt_d;
      conv_cnt_q <= conv_cnt_d;
    end
  end

  // Storage needs no reset: level gates everything read from it.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_byte;
  end

  assign level_o      = level_q;
  assign byte_count_o = byte_cnt_q;
  assign conv_count_o = conv_cnt_q;
endmodule

// File: tb/tb_to_lower_stream.sv
// Scoreboard bench for to_lower_stream; a CNT_W=4 copy shadows the same stream
// to exercise counter saturation.
module tb_to_lower_stream;
  logic clk, rst_n, clr;
  logic [2:0]  level, level4;
  logic [15:0] bcnt, ccnt;
  logic [3:0]  bcnt4, ccnt4;

  to_lower_stream_if in_s ();
  to_lower_stream_if out_s ();
  to_lower_stream_if in4 ();
  to_lower_stream_if out4 ();

  assign in4.valid = in_s.valid;
  assign in4.data  = in_s.data;
  assign out4.ready = out_s.ready;

  to_lower_stream #(.DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_if(in_s), .out_if(out_s), .clr_i(clr),
    .level_o(level), .byte_count_o(bcnt), .conv_count_o(ccnt));

  to_lower_stream #(.DEPTH(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_if(in4), .out_if(out4), .clr_i(clr),
    .level_o(level4), .byte_count_o(bcnt4), .conv_count_o(ccnt4));

  int checks = 0;
  int errors = 0;
  int n_push = 0;
  logic [7:0] q [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] lower(input logic [7:0] b);
    return (b >= 8'd65 && b <= 8'd90) ? b + 8'd32 : b;
  endfunction

  // Scoreboard: sample mid-cycle, record what the next rising edge will do.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (int'(level) != q.size()) begin
        errors++;
        $display("FAIL sb_level: got %0d, expected %0d", level, q.size());
      end
      if (out_s.valid && out_s.ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL sb_extra: got byte %0d, expected nothing", out_s.data);
        end else begin
          if (out_s.data !== q[0]) begin
            errors++;
            $display("FAIL sb_data: got %0d, expected %0d", out_s.data, q[0]);
          end
          void'(q.pop_front());
        end
      end
      if (in_s.valid && in_s.ready) begin
        q.push_back(lower(in_s.data));
        n_push++;
      end
    end
  end

  task automatic drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d bytes left, expected 0", name, q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0;
    in_s.valid = 1'b0; in_s.data = 8'h00; out_s.ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_s.valid !== 1'b0 || in_s.ready !== 1'b1 || level !== 3'd0 ||
        out_s.data !== 8'h00 || bcnt !== 16'd0 || ccnt !== 16'd0) begin
      errors++;
      $display("FAIL reset: ov=%b ir=%b lvl=%0d od=%0d bc=%0d cc=%0d, expected 0 1 0 0 0 0",
               out_s.valid, in_s.ready, level, out_s.data, bcnt, ccnt);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [7:0] src [5] = '{8'd72, 8'd65, 8'd90, 8'd97, 8'd122};
    logic [7:0] exp [5] = '{8'd104, 8'd97, 8'd122, 8'd97, 8'd122};
    out_s.ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_s.valid = 1'b1; in_s.data = src[i];
      @(posedge clk); #1;
      checks++;
      if (out_s.valid !== 1'b1 || out_s.data !== exp[i]) begin
        errors++;
        $display("FAIL basic_latency[%0d]: ov=%b od=%0d, expected 1 %0d", i, out_s.valid, out_s.data, exp[i]);
      end
    end
    in_s.valid = 1'b0;
    drain("basic");
    checks++;
    if (bcnt !== 16'd5 || ccnt !== 16'd3) begin
      errors++;
      $display("FAIL basic_counts: bc=%0d cc=%0d, expected 5 3", bcnt, ccnt);
    end
  endtask

  task automatic test_boundary();
    logic [7:0] src [8] = '{8'd64, 8'd91, 8'd40, 8'd183, 8'd131, 8'd235, 8'd127, 8'd0};
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    checks++;
    if (bcnt !== 16'd0 || ccnt !== 16'd0) begin
      errors++;
      $display("FAIL clr_idle: bc=%0d cc=%0d, expected 0 0", bcnt, ccnt);
    end
    out_s.ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_s.valid = 1'b1; in_s.data = src[i];
      @(posedge clk); #1;
      checks++;
      if (out_s.data !== src[i]) begin
        errors++;
        $display("FAIL boundary[%0d]: got %0d, expected %0d", i, out_s.data, src[i]);
      end
    end
    in_s.valid = 1'b0;
    drain("boundary");
    checks++;
    if (bcnt !== 16'd8 || ccnt !== 16'd0) begin
      errors++;
      $display("FAIL boundary_counts: bc=%0d cc=%0d, expected 8 0", bcnt, ccnt);
    end
  endtask

  task automatic test_full();
    out_s.ready = 1'b0;
    in_s.valid = 1'b1; in_s.data = 8'd65;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      in_s.data = in_s.data + 8'd1;
    end
    checks++;
    if (in_s.ready !== 1'b0 || level !== 3'd4) begin
      errors++;
      $display("FAIL full: ir=%b lvl=%0d, expected 0 4", in_s.ready, level);
    end
    out_s.ready = 1'b1;
    #1;
    checks++;
    if (in_s.ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready_comb: ir=%b, expected 0", in_s.ready);
    end
    @(posedge clk); #1;
    checks++;
    if (in_s.ready !== 1'b1 || level !== 3'd3) begin
      errors++;
      $display("FAIL full_release: ir=%b lvl=%0d, expected 1 3", in_s.ready, level);
    end
    @(posedge clk); #1;
    in_s.valid = 1'b0;
    drain("full");
  endtask

  task automatic test_random();
    int cyc = 0;
    int start = n_push;
    while ((n_push - start) < 2000 && cyc < 30000) begin
      in_s.valid  = 1'($urandom_range(0, 1));
      in_s.data   = 8'($urandom);
      out_s.ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      cyc++;
    end
    in_s.valid = 1'b0; out_s.ready = 1'b1;
    checks++;
    if ((n_push - start) < 2000) begin
      errors++;
      $display("FAIL random_count: pushed %0d, expected >= 2000", n_push - start);
    end
    drain("random");
  endtask

  task automatic test_saturation();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    out_s.ready = 1'b1;
    in_s.valid = 1'b1; in_s.data = 8'd65;
    repeat (20) begin
      @(posedge clk); #1;
    end
    in_s.valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bcnt4 !== 4'd15 || ccnt4 !== 4'd15 || bcnt !== 16'd20 || ccnt !== 16'd20) begin
      errors++;
      $display("FAIL saturate: bc4=%0d cc4=%0d bc=%0d cc=%0d, expected 15 15 20 20", bcnt4, ccnt4, bcnt, ccnt);
    end
    clr = 1'b1; in_s.valid = 1'b1; in_s.data = 8'd65;
    @(posedge clk); #1;
    clr = 1'b0; in_s.valid = 1'b0;
    checks++;
    if (bcnt4 !== 4'd0 || ccnt4 !== 4'd0 || bcnt !== 16'd0 || ccnt !== 16'd0) begin
      errors++;
      $display("FAIL clr_push: bc4=%0d cc4=%0d bc=%0d cc=%0d, expected 0 0 0 0", bcnt4, ccnt4, bcnt, ccnt);
    end
    checks++;
    if (out_s.valid !== 1'b1 || out_s.data !== 8'd97) begin
      errors++;
      $display("FAIL clr_push_data: ov=%b od=%0d, expected 1 97", out_s.valid, out_s.data);
    end
    drain("saturation");
  endtask

  task automatic test_async_reset();
    out_s.ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      in_s.valid = 1'b1; in_s.data = 8'(i + 64);
      @(posedge clk); #1;
    end
    in_s.valid = 1'b0;
    checks++;
    if (level !== 3'd3) begin
      errors++;
      $display("FAIL async_pre_level: got %0d, expected 3", level);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_s.valid !== 1'b0 || level !== 3'd0 || out_s.data !== 8'h00 ||
        bcnt !== 16'd0 || ccnt !== 16'd0 || in_s.ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: ov=%b lvl=%0d od=%0d bc=%0d cc=%0d ir=%b, expected 0 0 0 0 0 1",
               out_s.valid, level, out_s.data, bcnt, ccnt, in_s.ready);
    end
    q.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    in_s.valid = 1'b1; in_s.data = 8'd76; out_s.ready = 1'b1;
    @(posedge clk); #1;
    in_s.valid = 1'b0;
    checks++;
    if (out_s.valid !== 1'b1 || out_s.data !== 8'd108) begin
      errors++;
      $display("FAIL async_after: ov=%b od=%0d, expected 1 108", out_s.valid, out_s.data);
    end
    @(posedge clk); #1;
    checks++;
    if (out_s.valid !== 1'b0) begin
      errors++;
      $display("FAIL async_stale: ov=%b, expected 0", out_s.valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_full();
    test_random();
    test_saturation();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule

// File: doc/to_lower_stream.md
# to_lower_stream

Streaming ASCII lowercase converter: accepts bytes on a valid/ready input, maps 'A'–'Z' (65–90) to 'a'–'z' (97–122), and presents them in order on a valid/ready output through a small FIFO. It is the inverse-direction companion to the combinational uppercase converter and sits on the byte path between a character source (UART RX or test driver) and its consumer. It also keeps saturating statistics counters.

## Interface

- DEPTH, 4, FIFO entries; power of two, ≥ 2
- CNT_W, 16, width of statistics counters
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  source presents in_data
- in_ready  output  1  block can accept a byte this cycle
- in_data  input  8  input byte
- out_valid  output  1  out_data holds a valid byte
- out_ready  input  1  sink accepts out_data this cycle
- out_data  output  8  converted byte (head of FIFO)
- level  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH
- clr  input  1  synchronous clear of statistics counters
- byte_count  output  CNT_W  bytes accepted since reset/clr
- conv_count  output  CNT_W  accepted bytes that were changed (65–90)

## Operation

- Push = in_valid && in_ready; pop = out_valid && out_ready.
- in_ready = (level != DEPTH); out_valid = (level != 0). Both combinational from registered state only; neither depends on in_valid/out_ready.
- Conversion applied at write: if 65 ≤ in_data ≤ 90 store in_data + 32, else store in_data unchanged (includes 0–64, 91–255, bytes ≥ 128).
- FIFO: circular buffer, write pointer and read pointer of $clog2(DEPTH) bits wrapping DEPTH-1 → 0; level tracked explicitly (not derived from pointers).
- out_data = memory[rd_ptr] when out_valid, else 8'h00.
- Simultaneous push and pop (only possible when 0 < level < DEPTH): both occur, level unchanged.
- No bypass: a byte pushed when empty is not visible in the same cycle.
- Counters: byte_count += 1 per push; conv_count += 1 per push whose in_data was in 65–90. Both saturate at all-ones (no wrap).
- clr = 1: both counters become 0 at next edge; a push in the same cycle is not counted (clr wins). clr does not affect FIFO contents, pointers or handshakes.
- Order preserved; no byte dropped or duplicated.

## Timing

- Reset (rst_n low, asynchronous, any time): pointers = 0, level = 0, out_valid = 0, out_data = 8'h00, in_ready = 1, byte_count = 0, conv_count = 0. Reset mid-stream discards all stored bytes; memory contents need not be cleared.
- First edge after rst_n deasserts may push.
- Latency: byte pushed at edge N → out_valid = 1 with that byte after edge N (one cycle).
- Full (level = DEPTH): in_ready = 0 even if out_ready = 1 in that cycle; in_ready rises the cycle after a pop.
- Empty: out_valid = 0; out_ready ignored.
- Throughput: one byte per cycle sustained when out_ready held high and level between 1 and DEPTH-1.
- Counters update on the same edge as the push; visible cycle after.

## Test plan

- Reset then stream 72, 65, 90, 97, 122 with out_ready = 1 -> out 104, 97, 122, 97, 122 each one cycle after push; byte_count = 5, conv_count = 3.
- Boundary/non-ASCII bytes 64, 91, 40, 183, 131, 235, 127, 0 -> each emitted unchanged; conv_count stays 0, byte_count = 8.
- out_ready = 0, push 5 bytes 'A'..'E' with in_valid held -> in_ready falls after 4 pushes, level = 4; release out_ready -> 97..100 then 101 in order, no loss or duplicate.
- Random in_valid/out_ready (≥ 2000 bytes) against a reference queue model -> identical sequence; level never > 4; simultaneous push/pop leaves level unchanged.
- CNT_W = 4, push 20 bytes of 65 -> byte_count and conv_count saturate at 15; assert clr together with a push -> both read 0 next cycle, byte still delivered as 97.
- Assert rst_n low asynchronously (off clock edge) with level = 3 -> out_valid, level, counters 0 and out_data = 8'h00 immediately; after release, push 76 -> out 108 only.
